// File: rtl/sha1_pkg.sv
// Shared widths, constants and FSM state type for the SHA-1 message padder.
package sha1_pkg;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 160;
  localparam int unsigned LEN_W    = 64;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NBYTES   = BLOCK_W / BYTE_W;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned P_W      = 7;
  localparam int unsigned LENB_W   = LEN_W - 3;
  localparam int unsigned LEN_POS  = 56;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_PAD     = 3'd1,
    ST_EMIT    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_TAIL    = 3'd4
  } sha1_pad_state_t;

endpackage

// File: rtl/sha1_msg_padder_if.sv
// Byte-stream input and hash-core block handshake for the SHA-1 padder.
interface sha1_msg_padder_if;
  import sha1_pkg::*;

  logic               in_valid;
  logic [BYTE_W-1:0]  in_byte;
  logic               in_last;
  logic               in_ready;
  logic [BLOCK_W-1:0] blk;
  logic               blk_start;
  logic               hash_done;
  logic               msg_done;
  logic               busy;

  modport master (
    output in_valid, in_byte, in_last, hash_done,
    input  in_ready, blk, blk_start, msg_done, busy
  );

  modport slave (
    input  in_valid, in_byte, in_last, hash_done,
    output in_ready, blk, blk_start, msg_done, busy
  );

endinterface

// File: rtl/sha1_pad_buf.sv
// 64-byte block register: indexed byte write, marker + zero fill, length write, clear.
module sha1_pad_buf
  import sha1_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clr,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [BYTE_W-1:0]  i_wr_byte,
  input  logic               i_mark_en,
  input  logic [P_W-1:0]     i_mark_p,
  input  logic               i_len_en,
  input  logic [LEN_W-1:0]   i_len,
  output logic [BLOCK_W-1:0] o_blk
);

  logic [BLOCK_W-1:0] r_buf;
  logic [BLOCK_W-1:0] w_buf_nxt;

  // Clear first so a single cycle can clear, mark and write the length together.
  always_comb begin
    w_buf_nxt = i_clr ? '0 : r_buf;
    if (i_wr_en) begin
      w_buf_nxt[BLOCK_W-1-BYTE_W*32'(i_wr_idx) -: BYTE_W] = i_wr_byte;
    end
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (i_mark_en && (P_W'(k) == i_mark_p)) begin
        w_buf_nxt[BLOCK_W-1-BYTE_W*k -: BYTE_W] = PAD_BYTE;
      end else if (i_mark_en && (P_W'(k) > i_mark_p)) begin
        w_buf_nxt[BLOCK_W-1-BYTE_W*k -: BYTE_W] = '0;
      end
    end
    if (i_len_en) begin
      w_buf_nxt[LEN_W-1:0] = i_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf <= '0;
    end else begin
      r_buf <= w_buf_nxt;
    end
  end

  assign o_blk = r_buf;

endmodule

// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: byte stream in, FIPS 180-4 padded 512-bit blocks out to the hash core.
// Define SHA1_PAD_LEN_OUT_EN to expose the message bit length latched at PAD on len_bits_o.
module sha1_msg_padder
  import sha1_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  sha1_msg_padder_if.slave bus
`ifdef SHA1_PAD_LEN_OUT_EN
  ,
  output logic [LEN_W-1:0] len_bits_o
`endif
);

  sha1_pad_state_t    r_state, w_next;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [LENB_W-1:0]  r_len_bytes, w_len_nxt;
  logic [P_W-1:0]     r_p, w_p_nxt;
  logic               r_final, w_final_nxt;
  logic               r_tail, w_tail_nxt;
  logic               r_done_q;
  logic               r_in_ready, r_blk_start, r_msg_done, r_busy;
  logic               w_msg_done_nxt;
  logic               w_accept, w_rise;
  logic [LEN_W-1:0]   w_len_bits;
  logic               w_clr, w_wr_en, w_mark_en, w_len_en;
  logic [P_W-1:0]     w_mark_p;
  logic [BLOCK_W-1:0] w_blk;

  // in_ready is only ever high in COLLECT, so it alone qualifies acceptance.
  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_rise     = bus.hash_done & ~r_done_q;
  assign w_len_bits = {r_len_bytes, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_COLLECT: begin
        if (w_accept && bus.in_last) begin
          w_next = ST_PAD;
        end else if (w_accept && (r_idx == IDX_W'(NBYTES-1))) begin
          w_next = ST_EMIT;
        end
      end
      ST_PAD:  w_next = ST_EMIT;
      ST_EMIT: w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_rise) begin
          w_next = (!r_final && r_tail) ? ST_TAIL : ST_COLLECT;
        end
      end
      ST_TAIL: w_next = ST_EMIT;
      default: w_next = ST_COLLECT;
    endcase
  end

  always_comb begin
    w_idx_nxt      = r_idx;
    w_len_nxt      = r_len_bytes;
    w_p_nxt        = r_p;
    w_final_nxt    = r_final;
    w_tail_nxt     = r_tail;
    w_msg_done_nxt = 1'b0;
    w_clr          = 1'b0;
    w_wr_en        = 1'b0;
    w_mark_en      = 1'b0;
    w_mark_p       = r_p;
    w_len_en       = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (w_accept) begin
          w_wr_en   = 1'b1;
          w_idx_nxt = r_idx + IDX_W'(1);
          w_len_nxt = r_len_bytes + LENB_W'(1);
          if (bus.in_last) begin
            w_p_nxt = P_W'(r_idx) + P_W'(1);
          end
        end
      end
      // p==64 marks nothing; 56..63 leave no room for the length in this block.
      ST_PAD: begin
        w_mark_en = 1'b1;
        if (r_p <= P_W'(LEN_POS-1)) begin
          w_len_en    = 1'b1;
          w_final_nxt = 1'b1;
        end else begin
          w_tail_nxt  = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_rise && r_final) begin
          w_msg_done_nxt = 1'b1;
          w_clr          = 1'b1;
          w_idx_nxt      = '0;
          w_len_nxt      = '0;
          w_final_nxt    = 1'b0;
        end else if (w_rise && r_tail) begin
          w_tail_nxt     = 1'b0;
        end else if (w_rise) begin
          w_clr          = 1'b1;
          w_idx_nxt      = '0;
        end
      end
      ST_TAIL: begin
        w_clr       = 1'b1;
        w_mark_en   = (r_p == P_W'(NBYTES));
        w_mark_p    = '0;
        w_len_en    = 1'b1;
        w_final_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_len_bytes <= '0;
      r_p         <= '0;
      r_final     <= 1'b0;
      r_tail      <= 1'b0;
      r_done_q    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_blk_start <= 1'b0;
      r_msg_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_len_bytes <= w_len_nxt;
      r_p         <= w_p_nxt;
      r_final     <= w_final_nxt;
      r_tail      <= w_tail_nxt;
      r_done_q    <= bus.hash_done;
      r_in_ready  <= (w_next == ST_COLLECT);
      r_blk_start <= (w_next == ST_EMIT);
      r_msg_done  <= w_msg_done_nxt;
      r_busy      <= (w_next != ST_COLLECT) || (w_idx_nxt != '0);
    end
  end

  sha1_pad_buf u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr_en),
    .i_wr_idx  (r_idx),
    .i_wr_byte (bus.in_byte),
    .i_mark_en (w_mark_en),
    .i_mark_p  (w_mark_p),
    .i_len_en  (w_len_en),
    .i_len     (w_len_bits),
    .o_blk     (w_blk)
  );

`ifdef SHA1_PAD_LEN_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      len_bits_o <= '0;
    end else if (r_state == ST_PAD) begin
      len_bits_o <= w_len_bits;
    end
  end
`endif

  assign bus.in_ready  = r_in_ready;
  assign bus.blk       = w_blk;
  assign bus.blk_start = r_blk_start;
  assign bus.msg_done  = r_msg_done;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder: a reference padding model fills a block scoreboard
// and a small hash-core stand-in answers each blk_start with a hash_done pulse or level.
module tb_sha1_msg_padder;
  import sha1_pkg::*;

  logic clk;
  logic reset;
  sha1_msg_padder_if bus();
`ifdef SHA1_PAD_LEN_OUT_EN
  logic [LEN_W-1:0] len_bits_o;
`endif

  sha1_msg_padder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SHA1_PAD_LEN_OUT_EN
    ,
    .len_bits_o (len_bits_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_msg_done = 0;
  int exp_msgs = 0;
  int done_hold = 1;
  int raise_cyc = 0;
  int md_lat = 0;
  logic md_ready = 1'b0;
  logic [BLOCK_W-1:0] exp_q[$];
  int blk_cyc_q[$];
  int raise_cyc_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [7:0] mbyte(input int i, input int seed);
    return 8'(i * 37 + seed * 11 + 5);
  endfunction

  // Reference padding: append 0x80, zeros to 56 mod 64, then 64-bit bit length.
  task automatic push_expected(input int n, input int seed);
    logic [7:0] pm[$];
    logic [63:0] lb;
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < n; i++) pm.push_back(mbyte(i, seed));
    pm.push_back(8'h80);
    while ((pm.size() % 64) != 56) pm.push_back(8'h00);
    lb = 64'(n) << 3;
    for (int j = 7; j >= 0; j--) pm.push_back(lb[8*j +: 8]);
    for (int k = 0; k < pm.size() / 64; k++) begin
      b = '0;
      for (int m = 0; m < 64; m++) b[511-8*m -: 8] = pm[64*k + m];
      exp_q.push_back(b);
    end
  endtask

  // Hash-core stand-in: scoreboard compare on blk_start, then hash_done after a delay.
  initial begin : responder
    int pend;
    int dly;
    int hold;
    logic [BLOCK_W-1:0] exp;
    pend = 0;
    dly  = 0;
    hold = 0;
    bus.hash_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 0;
        dly  = 0;
        hold = 0;
        bus.hash_done = 1'b0;
      end else begin
        if (bus.blk_start) begin
          blk_cyc_q.push_back(cyc);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL blk_unexpected got=%h", bus.blk);
          end else begin
            exp = exp_q.pop_front();
            if (bus.blk !== exp) begin
              errors++;
              $display("FAIL blk got=%h exp=%h", bus.blk, exp);
            end
          end
          checks++;
          if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL emit_flags busy=%b in_ready=%b exp busy=1 in_ready=0", bus.busy, bus.in_ready);
          end
          pend++;
        end
        if (bus.msg_done === 1'b1) begin
          n_msg_done++;
          md_lat   = cyc - raise_cyc;
          md_ready = bus.in_ready;
        end
        if (hold > 0) begin
          hold--;
          if (hold == 0) bus.hash_done = 1'b0;
        end else if (pend > 0) begin
          if (dly < 3) begin
            dly++;
          end else begin
            bus.hash_done = 1'b1;
            raise_cyc = cyc;
            raise_cyc_q.push_back(cyc);
            hold = done_hold;
            pend--;
            dly = 0;
          end
        end
      end
    end
  end

  task automatic send_bytes(input int n, input int seed, input bit with_last,
                            output int t_last, output int t_64);
    int i;
    int guard;
    i = 0;
    guard = 0;
    t_last = -100;
    t_64 = -100;
    while (i < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      bus.in_valid = 1'b1;
      bus.in_byte  = mbyte(i, seed);
      bus.in_last  = with_last && (i == n - 1);
      if (bus.in_ready === 1'b1) begin
        if (i == 63) t_64 = cyc;
        if (i == n - 1) t_last = cyc;
        i++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL send_timeout sent=%0d exp=%0d", i, n);
    end
  endtask

  task automatic wait_msg();
    int g;
    g = 0;
    exp_msgs++;
    while (n_msg_done < exp_msgs && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_msg_done != exp_msgs) begin
      errors++;
      $display("FAIL msg_done_count got=%0d exp=%0d", n_msg_done, exp_msgs);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL blocks_missing got=%0d exp=0", exp_q.size());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic new_msg(input int n, input int seed, input int hold);
    blk_cyc_q.delete();
    raise_cyc_q.delete();
    done_hold = hold;
    push_expected(n, seed);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.blk !== '0) begin errors++; $display("FAIL rst_blk got=%h exp=0", bus.blk); end
    checks++;
    if (bus.blk_start !== 1'b0) begin errors++; $display("FAIL rst_blk_start got=%b exp=0", bus.blk_start); end
    checks++;
    if (bus.msg_done !== 1'b0) begin errors++; $display("FAIL rst_msg_done got=%b exp=0", bus.msg_done); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_single_block();
    int tl, t64;
    new_msg(55, 1, 1);
    send_bytes(55, 1, 1'b1, tl, t64);
    wait_msg();
    checks++;
    if (blk_cyc_q.size() != 1) begin errors++; $display("FAIL b55_count got=%0d exp=1", blk_cyc_q.size()); end
    checks++;
    if (blk_cyc_q[0] - tl != 2) begin errors++; $display("FAIL b55_latency got=%0d exp=2", blk_cyc_q[0] - tl); end
    checks++;
    if (md_lat != 1) begin errors++; $display("FAIL b55_msg_done_lat got=%0d exp=1", md_lat); end
    checks++;
    if (md_ready !== 1'b1) begin errors++; $display("FAIL b55_ready_at_done got=%b exp=1", md_ready); end
  endtask

  task automatic test_tail_56();
    int tl, t64;
    new_msg(56, 2, 1);
    send_bytes(56, 2, 1'b1, tl, t64);
    wait_msg();
    checks++;
    if (blk_cyc_q.size() != 2) begin errors++; $display("FAIL b56_count got=%0d exp=2", blk_cyc_q.size()); end
    checks++;
    if (blk_cyc_q[1] - raise_cyc_q[0] != 2) begin
      errors++;
      $display("FAIL b56_tail_latency got=%0d exp=2", blk_cyc_q[1] - raise_cyc_q[0]);
    end
    checks++;
    if (md_lat != 1) begin errors++; $display("FAIL b56_msg_done_lat got=%0d exp=1", md_lat); end
  endtask

  task automatic test_full_64();
    int tl, t64;
    new_msg(64, 3, 1);
    send_bytes(64, 3, 1'b1, tl, t64);
    wait_msg();
    checks++;
    if (blk_cyc_q.size() != 2) begin errors++; $display("FAIL b64_count got=%0d exp=2", blk_cyc_q.size()); end
    checks++;
    if (blk_cyc_q[0] - tl != 2) begin errors++; $display("FAIL b64_latency got=%0d exp=2", blk_cyc_q[0] - tl); end
  endtask

  task automatic test_level_done();
    int tl, t64;
    new_msg(56, 4, 5);
    send_bytes(56, 4, 1'b1, tl, t64);
    wait_msg();
    checks++;
    if (raise_cyc_q.size() != 2) begin errors++; $display("FAIL lvl_raises got=%0d exp=2", raise_cyc_q.size()); end
    checks++;
    if (md_lat != 1) begin errors++; $display("FAIL lvl_msg_done_lat got=%0d exp=1", md_lat); end
    done_hold = 1;
  endtask

  task automatic test_backpressure();
    int tl, t64;
    new_msg(100, 5, 1);
    send_bytes(100, 5, 1'b1, tl, t64);
    wait_msg();
    checks++;
    if (blk_cyc_q.size() != 2) begin errors++; $display("FAIL bp_count got=%0d exp=2", blk_cyc_q.size()); end
    checks++;
    if (blk_cyc_q[0] - t64 != 1) begin errors++; $display("FAIL bp_latency got=%0d exp=1", blk_cyc_q[0] - t64); end
  endtask

  task automatic test_reset_mid();
    int tl, t64;
    blk_cyc_q.delete();
    send_bytes(30, 6, 1'b0, tl, t64);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.blk !== '0 ||
        bus.blk_start !== 1'b0 || bus.msg_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs busy=%b in_ready=%b blk_nz=%b start=%b done=%b exp all 0",
               bus.busy, bus.in_ready, (bus.blk != '0), bus.blk_start, bus.msg_done);
    end
    new_msg(55, 1, 1);
    send_bytes(55, 1, 1'b1, tl, t64);
    wait_msg();
    checks++;
    if (blk_cyc_q.size() != 1) begin errors++; $display("FAIL mid_count got=%0d exp=1", blk_cyc_q.size()); end
  endtask

`ifdef SHA1_PAD_LEN_OUT_EN
  task automatic test_len_out();
    int tl, t64;
    checks++;
    if (len_bits_o !== 64'h1b8) begin errors++; $display("FAIL len_held got=%h exp=1b8", len_bits_o); end
    new_msg(130, 7, 1);
    send_bytes(130, 7, 1'b1, tl, t64);
    wait_msg();
    checks++;
    if (len_bits_o !== 64'h410) begin errors++; $display("FAIL len_out got=%h exp=410", len_bits_o); end
    checks++;
    if (blk_cyc_q.size() != 3) begin errors++; $display("FAIL len_count got=%0d exp=3", blk_cyc_q.size()); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = '0;
    bus.in_last  = 1'b0;
    reset        = 1'b1;
    test_reset();
    test_single_block();
    test_tail_56();
    test_full_64();
    test_level_done();
    test_backpressure();
    test_reset_mid();
`ifdef SHA1_PAD_LEN_OUT_EN
    test_len_out();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
